// File: rtl/coin_field_manager.sv
// Coin field owner: loads coin positions from ROM, scans for pacman overlap,
// keeps liveness and score, and answers per-pixel coin hits for the drawer.
module coin_field_manager #(
    parameter int unsigned NUM_COINS  = 8,
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 9,
    parameter int unsigned COIN_SIZE  = 15,
    parameter int unsigned PAC_SIZE   = 25,
    parameter int unsigned COIN_VALUE = 10,
    parameter int unsigned SCORE_W    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           restart,
    input  logic                           pac_killed,
    input  logic [X_W-1:0]                 pacman_left_x,
    input  logic [Y_W-1:0]                 pacman_top_y,
    output logic [$clog2(NUM_COINS)-1:0]   rom_addr,
    input  logic [X_W+Y_W:0]               rom_data,
    input  logic [X_W-1:0]                 px_x,
    input  logic [Y_W-1:0]                 px_y,
    output logic                           pixel_on,
    output logic                           coins_ready,
    output logic [NUM_COINS-1:0]           coin_alive,
    output logic [$clog2(NUM_COINS+1)-1:0] coins_left,
    output logic [SCORE_W-1:0]             score,
    output logic                           coin_eaten,
    output logic [$clog2(NUM_COINS)-1:0]   eaten_idx,
    output logic                           level_clear
);

    localparam int unsigned AW  = $clog2(NUM_COINS);
    localparam int unsigned CW  = $clog2(NUM_COINS + 1);
    localparam int unsigned XW1 = X_W + 1;
    localparam int unsigned YW1 = Y_W + 1;
    localparam int unsigned SW1 = SCORE_W + 1;
    localparam logic [AW-1:0]  LAST_IDX  = AW'(NUM_COINS - 1);
    localparam logic [SW1-1:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

    typedef enum logic [1:0] {
        S_LOAD_ADDR,
        S_LOAD_WAIT,
        S_RUN,
        S_CLEAR
    } state_t;

    state_t state, state_next;

    logic [X_W-1:0]       coin_x [NUM_COINS];
    logic [Y_W-1:0]       coin_y [NUM_COINS];
    logic [AW-1:0]        scan;
    logic                 capture;
    logic                 hit;
    logic                 overlap;
    logic                 pixel_hit;
    logic [NUM_COINS-1:0] alive_next;
    logic [CW-1:0]        left_next;
    logic [SW1-1:0]       score_sum;
    logic                 rom_en;
    logic [X_W-1:0]       rom_x;
    logic [Y_W-1:0]       rom_y;

    assign {rom_en, rom_x, rom_y} = rom_data;

    // Inclusive box overlap of the scanned coin against pacman, one bit wider so nothing wraps
    always_comb begin
        overlap = (XW1'(coin_x[scan]) <= XW1'(pacman_left_x) + XW1'(PAC_SIZE)) &&
                  (XW1'(pacman_left_x) <= XW1'(coin_x[scan]) + XW1'(COIN_SIZE)) &&
                  (YW1'(coin_y[scan]) <= YW1'(pacman_top_y) + YW1'(PAC_SIZE)) &&
                  (YW1'(pacman_top_y) <= YW1'(coin_y[scan]) + YW1'(COIN_SIZE));
    end

    always_comb begin
        pixel_hit = 1'b0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (coin_alive[k] &&
                (XW1'(px_x) >= XW1'(coin_x[k])) &&
                (XW1'(px_x) <= XW1'(coin_x[k]) + XW1'(COIN_SIZE)) &&
                (YW1'(px_y) >= YW1'(coin_y[k])) &&
                (YW1'(px_y) <= YW1'(coin_y[k]) + YW1'(COIN_SIZE))) begin
                pixel_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_LOAD_ADDR;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle strobes; restart overrides everything including a hit
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        hit        = 1'b0;
        case (state)
            S_LOAD_ADDR: state_next = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                capture    = 1'b1;
                state_next = (rom_addr == LAST_IDX) ? S_RUN : S_LOAD_ADDR;
            end
            S_RUN: begin
                hit = coin_alive[scan] & ~pac_killed & overlap;
                if (coins_left == '0) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: state_next = S_CLEAR;
            default: state_next = S_LOAD_ADDR;
        endcase
        if (restart) begin
            state_next = S_LOAD_ADDR;
            capture    = 1'b0;
            hit        = 1'b0;
        end
    end

    always_comb begin
        alive_next = coin_alive;
        if (restart) begin
            alive_next = '0;
        end else if (capture) begin
            alive_next[rom_addr] = rom_en;
        end else if (hit) begin
            alive_next[scan] = 1'b0;
        end
        left_next = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            left_next = left_next + CW'(alive_next[k]);
        end
        score_sum = SW1'(score) + SW1'(COIN_VALUE);
        if (score_sum > SCORE_MAX) begin
            score_sum = SCORE_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rom_addr    <= '0;
            scan        <= '0;
            coin_alive  <= '0;
            coins_left  <= '0;
            score       <= '0;
            coins_ready <= 1'b0;
            coin_eaten  <= 1'b0;
            eaten_idx   <= '0;
            level_clear <= 1'b0;
            pixel_on    <= 1'b0;
            for (int k = 0; k < NUM_COINS; k++) begin
                coin_x[k] <= '0;
                coin_y[k] <= '0;
            end
        end else begin
            coin_alive  <= alive_next;
            coins_left  <= left_next;
            coins_ready <= (state_next == S_RUN) || (state_next == S_CLEAR);
            level_clear <= (state_next == S_CLEAR);
            coin_eaten  <= hit;
            pixel_on    <= coins_ready & ~restart & pixel_hit;
            if (hit) begin
                eaten_idx <= scan;
                score     <= score_sum[SCORE_W-1:0];
            end
            if (capture) begin
                coin_x[rom_addr] <= rom_x;
                coin_y[rom_addr] <= rom_y;
            end
            if (restart) begin
                rom_addr <= '0;
                scan     <= '0;
            end else begin
                if (capture && (rom_addr != LAST_IDX)) begin
                    rom_addr <= rom_addr + AW'(1);
                end
                if (state == S_RUN) begin
                    scan <= (scan == LAST_IDX) ? '0 : scan + AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_coin_field_manager.sv
// Directed bench for coin_field_manager: table of single-coin overlap/pixel vectors
// plus hand sequences for load timing, eating, level clear, restart and mid-load reset.
module tb_coin_field_manager;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic        pac_killed;
    logic [9:0]  pacman_left_x;
    logic [8:0]  pacman_top_y;
    logic [2:0]  rom_addr;
    logic [19:0] rom_data;
    logic [9:0]  px_x;
    logic [8:0]  px_y;
    logic        pixel_on;
    logic        coins_ready;
    logic [7:0]  coin_alive;
    logic [3:0]  coins_left;
    logic [15:0] score;
    logic        coin_eaten;
    logic [2:0]  eaten_idx;
    logic        level_clear;

    logic [19:0] rom [8];
    int checks = 0;
    int errors = 0;
    int exp_score = 0;

    typedef struct {
        logic [9:0] cx;
        logic [8:0] cy;
        logic [9:0] pacx;
        logic [8:0] pacy;
        logic       killed;
        logic [9:0] pxx;
        logic [8:0] pxy;
        int         eaten;
        logic       pix;
    } vec_t;

    vec_t vecs[11];

    coin_field_manager dut (
        .clk(clk), .reset(reset), .restart(restart), .pac_killed(pac_killed),
        .pacman_left_x(pacman_left_x), .pacman_top_y(pacman_top_y),
        .rom_addr(rom_addr), .rom_data(rom_data), .px_x(px_x), .px_y(px_y),
        .pixel_on(pixel_on), .coins_ready(coins_ready), .coin_alive(coin_alive),
        .coins_left(coins_left), .score(score), .coin_eaten(coin_eaten),
        .eaten_idx(eaten_idx), .level_clear(level_clear)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for an address appears one cycle later
    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!coins_ready && n < 40) begin
            tick();
            n++;
        end
        check(name, n, 16);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic wait_eat(input string name);
        int n;
        n = 0;
        while (!coin_eaten && n < 9) begin
            tick();
            n++;
        end
        check(name, coin_eaten, 1);
    endtask

    task automatic count_eats(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (coin_eaten) cnt++;
        end
    endtask

    task automatic pac_far();
        pacman_left_x = 10'd700;
        pacman_top_y  = 9'd400;
        pac_killed    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_alive"}, coin_alive, 0);
        check({tag, "_left"}, coins_left, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_ready"}, coins_ready, 0);
        check({tag, "_eaten"}, coin_eaten, 0);
        check({tag, "_idx"}, eaten_idx, 0);
        check({tag, "_clear"}, level_clear, 0);
        check({tag, "_pixel"}, pixel_on, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        vecs[0]  = '{10'd100,  9'd50,  10'd90,   9'd40,  1'b0, 10'd107,  9'd57,  1, 1'b1};
        vecs[1]  = '{10'd100,  9'd50,  10'd90,   9'd40,  1'b1, 10'd116,  9'd50,  0, 1'b0};
        vecs[2]  = '{10'd1010, 9'd100, 10'd1000, 9'd100, 1'b0, 10'd1023, 9'd115, 1, 1'b1};
        vecs[3]  = '{10'd0,    9'd100, 10'd1000, 9'd100, 1'b0, 10'd0,    9'd99,  0, 1'b0};
        vecs[4]  = '{10'd100,  9'd50,  10'd115,  9'd50,  1'b0, 10'd115,  9'd65,  1, 1'b1};
        vecs[5]  = '{10'd100,  9'd50,  10'd116,  9'd50,  1'b0, 10'd99,   9'd50,  0, 1'b0};
        vecs[6]  = '{10'd100,  9'd50,  10'd75,   9'd50,  1'b0, 10'd100,  9'd50,  1, 1'b1};
        vecs[7]  = '{10'd100,  9'd50,  10'd100,  9'd24,  1'b0, 10'd100,  9'd66,  0, 1'b0};
        vecs[8]  = '{10'd100,  9'd50,  10'd100,  9'd25,  1'b0, 10'd108,  9'd49,  1, 1'b0};
        vecs[9]  = '{10'd100,  9'd500, 10'd100,  9'd495, 1'b0, 10'd100,  9'd511, 1, 1'b1};
        vecs[10] = '{10'd0,    9'd0,   10'd100,  9'd500, 1'b0, 10'd15,   9'd15,  0, 1'b1};

        rom[0] = {1'b1, 10'd100, 9'd50};
        rom[1] = {1'b1, 10'd200, 9'd50};
        for (int k = 2; k < 8; k++) rom[k] = {1'b0, 10'd400, 9'd300};
        reset = 1'b0;
        restart = 1'b0;
        px_x = 10'd0;
        px_y = 9'd0;
        pac_far();

        // Reset, load timing and enabled-only liveness
        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b1;
        wait_ready("load_cycles");
        check("load_alive", coin_alive, 8'b0000_0011);
        check("load_left", coins_left, 2);

        // Eat coin 0 once while pacman stays on it
        pacman_left_x = 10'd90;
        pacman_top_y  = 9'd40;
        wait_eat("eat0_pulse");
        check("eat0_idx", eaten_idx, 0);
        check("eat0_score", score, 10);
        check("eat0_alive", coin_alive, 8'b0000_0010);
        check("eat0_left", coins_left, 1);
        count_eats(16, cnt);
        check("eat0_no_repeat", cnt, 0);

        // Killed pacman cannot eat; then eats coin 1 and clears the level
        pacman_left_x = 10'd190;
        pac_killed    = 1'b1;
        count_eats(16, cnt);
        check("killed_no_eat", cnt, 0);
        check("killed_score", score, 10);
        pac_killed = 1'b0;
        wait_eat("eat1_pulse");
        check("eat1_idx", eaten_idx, 1);
        check("eat1_score", score, 20);
        check("eat1_left", coins_left, 0);
        check("eat1_clear_early", level_clear, 0);
        tick();
        check("clear_set", level_clear, 1);
        tick();
        tick();
        tick();
        check("clear_held", level_clear, 1);
        check("clear_ready", coins_ready, 1);

        // Restart reloads the field but keeps score
        pac_far();
        pulse_restart();
        check("rs_clear", level_clear, 0);
        check("rs_ready", coins_ready, 0);
        check("rs_alive", coin_alive, 0);
        check("rs_addr", rom_addr, 0);
        wait_ready("rs_load_cycles");
        check("rs_alive_loaded", coin_alive, 8'b0000_0011);
        check("rs_score", score, 20);
        exp_score = 20;

        // Table: coin 0 placement vs pacman box and pixel probe
        rom[1] = {1'b1, 10'd300, 9'd200};
        foreach (vecs[i]) begin
            rom[0] = {1'b1, vecs[i].cx, vecs[i].cy};
            pulse_restart();
            wait_ready($sformatf("v%0d_ready", i));
            px_x = vecs[i].pxx;
            px_y = vecs[i].pxy;
            tick();
            check($sformatf("v%0d_pixel", i), pixel_on, vecs[i].pix);
            pacman_left_x = vecs[i].pacx;
            pacman_top_y  = vecs[i].pacy;
            pac_killed    = vecs[i].killed;
            count_eats(18, cnt);
            check($sformatf("v%0d_eats", i), cnt, vecs[i].eaten);
            check($sformatf("v%0d_alive0", i), coin_alive[0], (vecs[i].eaten == 0) ? 1 : 0);
            if (vecs[i].eaten != 0) exp_score += 10;
            check($sformatf("v%0d_score", i), score, exp_score);
            pac_far();
        end

        // Reset in the middle of a reload
        rom[0] = {1'b1, 10'd100, 9'd50};
        rom[1] = {1'b1, 10'd200, 9'd50};
        pulse_restart();
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        tick();
        check_reset_values("midrst");
        reset = 1'b1;
        wait_ready("midrst_load_cycles");
        check("midrst_alive", coin_alive, 8'b0000_0011);

        // Disabled coin never drawn; coin 0 drawn until eaten
        px_x = 10'd405;
        px_y = 9'd305;
        tick();
        check("pix_disabled", pixel_on, 0);
        px_x = 10'd107;
        px_y = 9'd57;
        tick();
        check("pix_alive", pixel_on, 1);
        pacman_left_x = 10'd90;
        pacman_top_y  = 9'd40;
        wait_eat("pix_eat");
        tick();
        check("pix_after_eat", pixel_on, 0);
        check("pix_score", score, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
